seg7_digit_capture: RTL
=======================

// Module: seg7_digit_capture
// PURPOSE
//  Receive-side counterpart of the BCD-to-7-segment encoder. Samples an
//  active-low 7-segment pattern bus (from an external display driver or
//  a looped-back HEX output), filters glitches by requiring a pattern to
//  hold for STABLE_CNT consecutive samples, and decodes it back to a BCD
//  digit. Each new stable digit is offered once on a valid/ready port.
//  Sits between the board segment pins and the lab's digit-consuming logic.
// PARAMETERS
//  STABLE_CNT  4  consecutive identical samples to accept a pattern (1..255)
//  CNT_W       8  width of the saturating invalid-pattern error counter
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  reset        in   1      synchronous, active-high
//  sample_en    in   1      take a sample of leds this cycle
//  leds         in   7      segment pattern, bit i = segment i, 0 = lit
//  digit        out  4      decoded BCD digit, valid when digit_valid=1
//  digit_valid  out  1      digit held for consumer
//  digit_ready  in   1      consumer accepts digit when valid&ready
//  blank        out  1      last accepted pattern was all-off (7'h7F)
//  err_count    out  CNT_W  count of stable invalid patterns, saturating
//  overflow     out  1      1-cycle pulse: new digit dropped, slot full
// BEHAVIOUR
//  Decode table (leds->digit): 40->0 79->1 24->2 30->3 19->4 12->5 02->6
//   78->7 00->8 10->9 (hex, 7-bit); 7F = blank; any other = invalid.
//  Reset: digit=0, digit_valid=0, blank=1, err_count=0, overflow=0;
//   cand=7'h7F, run=0, last=7'h7F (power-up blank is not reported).
//  Tracker (updated only on cycles with sample_en=1):
//   - leds==cand: run <= min(run+1, STABLE_CNT); else cand<=leds, run<=1.
//   - Lock event when run becomes STABLE_CNT (one event per stable run;
//     further matching samples do nothing). STABLE_CNT=1: every change
//     of pattern locks on its first sample.
//   - On lock with cand==last: no action (same pattern re-stable).
//   - On lock with cand!=last: last<=cand, then by class:
//     digit: offer to output slot; blank<=0.
//     blank: blank<=1, nothing offered.
//     invalid: err_count<=err_count+1 (holds at all-ones); blank<=0.
//  Output slot (1 entry, states IDLE/FULL):
//   - Latency: lock at edge t -> digit/digit_valid updated at edge t+1.
//   - IDLE + offer: load digit, digit_valid<=1 (FULL).
//   - FULL, valid&ready, no offer: digit_valid<=0 (IDLE).
//   - FULL + offer + ready same cycle: load new digit, digit_valid stays 1.
//   - FULL + offer, ready=0: keep old digit, drop new, overflow=1 for one
//     cycle; last still updated to new pattern.
//   - digit stable while digit_valid=1; digit_ready ignored when IDLE.
//  Repeats: 5,5,5... reports once; 5 then blank then 5 reports twice.
//  sample_en=0 freezes tracker; output handshake still proceeds.
//  Reset mid-run or with slot FULL: all state to reset values next edge,
//   pending digit discarded, no overflow pulse.
// TESTING
//  1 STABLE_CNT=4, leds=7'h24 sampled 4x, ready=1 -> digit=2 valid one
//    cycle, blank=0; 8 more 7'h24 samples -> no further valid.
//  2 Glitch: 7'h30 x3, 7'h7F x1, 7'h30 x3 -> nothing; 4th consecutive
//    7'h30 -> digit=3.
//  3 ready=0: lock 7'h19 (4), then 7'h12 -> digit stays 4, overflow
//    pulses once; ready=1 -> 4 accepted, valid drops.
//  4 7'h55 stable x4 -> err_count=1, no valid; CNT_W=2, 5 distinct
//    invalid locks -> err_count saturates at 3.
//  5 Lock 7'h10 (9) with ready=0, assert reset one cycle -> digit_valid=0,
//    blank=1, err_count=0; then 7'h7F x4 -> nothing reported.
//  6 FULL digit 1 with ready=1 on same cycle 7'h78 locks -> valid stays 1,
//    digit=7, no overflow.

Source files
------------

// File: rtl/seg7_digit_capture.sv
// rtl/seg7_digit_capture.sv - glitch-filtered 7-segment pattern capture and BCD decode
//
// Purpose: samples an active-low 7-segment bus, accepts a pattern once it has
// been seen STABLE_CNT consecutive samples in a row, decodes it to a BCD digit
// and offers each newly stable digit once on a single-entry valid/ready slot.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        synchronous, active-high
//   sample_en    take a sample of leds this cycle
//   leds         segment pattern, bit i = segment i, 0 = lit
//   digit        decoded BCD digit, stable while digit_valid=1
//   digit_valid  digit held for consumer
//   digit_ready  consumer accepts digit when valid&ready
//   blank        last accepted pattern was all-off (7'h7F)
//   err_count    saturating count of stable invalid patterns
//   overflow     1-cycle pulse: new digit dropped because the slot was full
module seg7_digit_capture #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [6:0]       leds,
  output logic [3:0]       digit,
  output logic             digit_valid,
  input  logic             digit_ready,
  output logic             blank,
  output logic [CNT_W-1:0] err_count,
  output logic             overflow
);

  localparam logic [7:0] STABLE    = 8'(STABLE_CNT);
  localparam logic [6:0] PAT_BLANK = 7'h7F;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_FULL   = 1'b1;

  logic [6:0]       cand_q, cand_d;
  logic [7:0]       run_q, run_d;
  logic [6:0]       last_q, last_d;
  logic             lock_q, lock_d;
  logic [6:0]       lock_pat_q, lock_pat_d;
  logic [0:0]       state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic             blank_q, blank_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             ovf_q, ovf_d;

  logic             match;
  logic             offer;
  logic [4:0]       dec;

  // Returns {is_digit, bcd}; is_digit=0 for blank and invalid patterns.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    unique case (p)
      7'h40:   r = {1'b1, 4'd0};
      7'h79:   r = {1'b1, 4'd1};
      7'h24:   r = {1'b1, 4'd2};
      7'h30:   r = {1'b1, 4'd3};
      7'h19:   r = {1'b1, 4'd4};
      7'h12:   r = {1'b1, 4'd5};
      7'h02:   r = {1'b1, 4'd6};
      7'h78:   r = {1'b1, 4'd7};
      7'h00:   r = {1'b1, 4'd8};
      7'h10:   r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    cand_d     = cand_q;
    run_d      = run_q;
    last_d     = last_q;
    lock_d     = 1'b0;
    lock_pat_d = lock_pat_q;
    state_d    = state_q;
    digit_d    = digit_q;
    blank_d    = blank_q;
    err_d      = err_q;
    ovf_d      = 1'b0;
    offer      = 1'b0;
    match      = (leds == cand_q);
    dec        = decode(lock_pat_q);

    // Tracker: the lock is registered so the slot reacts one edge later.
    if (sample_en) begin
      if (match) begin
        run_d = (run_q == STABLE) ? run_q : run_q + 8'd1;
      end else begin
        cand_d = leds;
        run_d  = 8'd1;
      end
      // Only the sample that brings run up to STABLE locks; a run already
      // saturated at STABLE that keeps matching does not lock again.
      lock_d     = (run_d == STABLE) && !(match && run_q == STABLE);
      lock_pat_d = leds;
    end

    // Classify a lock on a pattern different from the last accepted one.
    if (lock_q && lock_pat_q != last_q) begin
      last_d = lock_pat_q;
      if (dec[4]) begin
        offer   = 1'b1;
        blank_d = 1'b0;
      end else if (lock_pat_q == PAT_BLANK) begin
        blank_d = 1'b1;
      end else begin
        blank_d = 1'b0;
        if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
      end
    end

    // Single-entry output slot.
    case (state_q)
      ST_IDLE: begin
        if (offer) begin
          digit_d = dec[3:0];
          state_d = ST_FULL;
        end
      end
      default: begin
        if (offer) begin
          if (digit_ready) digit_d = dec[3:0];
          else             ovf_d   = 1'b1;
        end else if (digit_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q     <= PAT_BLANK;
      run_q      <= 8'd0;
      last_q     <= PAT_BLANK;
      lock_q     <= 1'b0;
      lock_pat_q <= PAT_BLANK;
      state_q    <= ST_IDLE;
      digit_q    <= 4'd0;
      blank_q    <= 1'b1;
      err_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      run_q      <= run_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_pat_q <= lock_pat_d;
      state_q    <= state_d;
      digit_q    <= digit_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = (state_q == ST_FULL);
  assign blank       = blank_q;
  assign err_count   = err_q;
  assign overflow    = ovf_q;

endmodule
